// File: rtl/video_stream_pixel_op.sv
// ============================================================================
// video_stream_pixel_op
//
// Per-component pixel operation on an AXI4-Stream video stream. Each
// component is bypassed, bitwise-inverted or binary-thresholded, and each
// channel has its own enable bit in MASK. An AXI4-Lite register bank holds
// the settings. A shadow (active) copy of the settings is loaded only on an
// accepted start-of-frame beat, so a frame never changes its processing
// part-way through.
//
// Register map (word index = addr[3:2]):
//   0x0 CTRL   : bit0 EN, bit1 MODE (0 = invert, 1 = threshold)
//   0x4 MASK   : bits [C_CHANNELS-1:0], one enable bit per component
//   0x8 THRESH : bits [C_COMPONENT_WIDTH-1:0], unsigned threshold
//   0xC FRAMES : read-only count of SOF beats delivered at the output;
//                any write clears it
//
// Ports:
//   ACLK, ARESETN     : clock and synchronous active-low reset
//   s_axi_*           : AXI4-Lite slave (register bank)
//   s_axis_*          : input video  (tuser = start of frame, tlast = end of line)
//   m_axis_*          : output video, one register stage (latency 1)
// ============================================================================
module video_stream_pixel_op #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_CHANNELS         = 3,
    parameter int C_COMPONENT_WIDTH  = 8
) (
    input  logic                                      ACLK,
    input  logic                                      ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             s_axi_awaddr,
    input  logic [2:0]                                s_axi_awprot,
    input  logic                                      s_axi_awvalid,
    output logic                                      s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           s_axi_wstrb,
    input  logic                                      s_axi_wvalid,
    output logic                                      s_axi_wready,
    output logic [1:0]                                s_axi_bresp,
    output logic                                      s_axi_bvalid,
    input  logic                                      s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             s_axi_araddr,
    input  logic [2:0]                                s_axi_arprot,
    input  logic                                      s_axi_arvalid,
    output logic                                      s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             s_axi_rdata,
    output logic [1:0]                                s_axi_rresp,
    output logic                                      s_axi_rvalid,
    input  logic                                      s_axi_rready,

    input  logic [C_CHANNELS*C_COMPONENT_WIDTH-1:0]   s_axis_tdata,
    input  logic                                      s_axis_tuser,
    input  logic                                      s_axis_tlast,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,

    output logic [C_CHANNELS*C_COMPONENT_WIDTH-1:0]   m_axis_tdata,
    output logic                                      m_axis_tuser,
    output logic                                      m_axis_tlast,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready
);

    localparam int CW = C_COMPONENT_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0]            RESP_OKAY    = 2'b00;
    localparam logic [CW-1:0]         THRESH_RESET = CW'(1) << (CW - 1);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_MASK   = 2'd1,
        REG_THRESH = 2'd2,
        REG_FRAMES = 2'd3
    } reg_idx_e;

    // ------------------------------------------------------------------------
    // Programmed registers, active (shadow) set and frame counter
    // ------------------------------------------------------------------------
    logic                  ctrl_en, ctrl_mode;
    logic [C_CHANNELS-1:0] mask_reg;
    logic [CW-1:0]         thresh_reg;
    logic                  act_en, act_mode;
    logic [C_CHANNELS-1:0] act_mask;
    logic [CW-1:0]         act_thresh;
    logic [31:0]           frames;

    // Register contents as 32-bit bus words, unused bits zero.
    logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_word, mask_word, thresh_word;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        ctrl_word                   = '0;
        ctrl_word[0]                = ctrl_en;
        ctrl_word[1]                = ctrl_mode;
        mask_word                   = '0;
        mask_word[C_CHANNELS-1:0]   = mask_reg;
        thresh_word                 = '0;
        thresh_word[CW-1:0]         = thresh_reg;
    end

    // ------------------------------------------------------------------------
    // AXI4-Lite write channel
    // ------------------------------------------------------------------------
    reg_idx_e                      wr_idx;
    logic                          wr_fire;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_old, wr_merged;

    assign wr_idx  = reg_idx_e'(s_axi_awaddr[3:2]);
    assign wr_fire = s_axi_awready && s_axi_awvalid && s_axi_wvalid;

    function automatic logic [C_S_AXI_DATA_WIDTH-1:0] apply_strobe(
        input logic [C_S_AXI_DATA_WIDTH-1:0] old_word,
        input logic [C_S_AXI_DATA_WIDTH-1:0] new_word,
        input logic [SW-1:0]                 strb
    );
        logic [C_S_AXI_DATA_WIDTH-1:0] result;
        result = old_word;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) result[8*b +: 8] = new_word[8*b +: 8];
        end
        return result;
    endfunction

    always_comb begin
        case (wr_idx)
            REG_CTRL:   wr_old = ctrl_word;
            REG_MASK:   wr_old = mask_word;
            REG_THRESH: wr_old = thresh_word;
            default:    wr_old = '0;
        endcase
        wr_merged = apply_strobe(wr_old, s_axi_wdata, s_axi_wstrb);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and evaluation order cannot matter.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            ctrl_en       <= 1'b0;
            ctrl_mode     <= 1'b0;
            mask_reg      <= '1;
            thresh_reg    <= THRESH_RESET;
        end else begin
            // Single-cycle ready pulse; the !awready term stops a second pulse
            // while the accepted transfer's response is still being formed.
            s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= RESP_OKAY;
                case (wr_idx)
                    REG_CTRL: begin
                        ctrl_en   <= wr_merged[0];
                        ctrl_mode <= wr_merged[1];
                    end
                    REG_MASK:   mask_reg   <= wr_merged[C_CHANNELS-1:0];
                    REG_THRESH: thresh_reg <= wr_merged[CW-1:0];
                    default: ;
                endcase
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // AXI4-Lite read channel
    // ------------------------------------------------------------------------
    reg_idx_e rd_idx;
    assign rd_idx = reg_idx_e'(s_axi_araddr[3:2]);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (s_axi_arready && s_axi_arvalid) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rresp  <= RESP_OKAY;
                case (rd_idx)
                    REG_CTRL:   s_axi_rdata <= ctrl_word;
                    REG_MASK:   s_axi_rdata <= mask_word;
                    REG_THRESH: s_axi_rdata <= thresh_word;
                    default:    s_axi_rdata <= frames;
                endcase
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stream handshake and shadowing
    // ------------------------------------------------------------------------
    logic s_fire, m_fire;
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;

    // An SOF beat must already use the freshly loaded settings, so it bypasses
    // the active set and reads the programmed registers directly.
    logic                  eff_en, eff_mode;
    logic [C_CHANNELS-1:0] eff_mask;
    logic [CW-1:0]         eff_thresh;
    assign eff_en     = s_axis_tuser ? ctrl_en    : act_en;
    assign eff_mode   = s_axis_tuser ? ctrl_mode  : act_mode;
    assign eff_mask   = s_axis_tuser ? mask_reg   : act_mask;
    assign eff_thresh = s_axis_tuser ? thresh_reg : act_thresh;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            act_en     <= 1'b0;
            act_mode   <= 1'b0;
            act_mask   <= '1;
            act_thresh <= THRESH_RESET;
        end else if (s_fire && s_axis_tuser) begin
            act_en     <= ctrl_en;
            act_mode   <= ctrl_mode;
            act_mask   <= mask_reg;
            act_thresh <= thresh_reg;
        end
    end

    // ------------------------------------------------------------------------
    // Per-component operation
    // ------------------------------------------------------------------------
    function automatic logic [CW-1:0] pixel_op(
        input logic [CW-1:0] comp,
        input logic          mode,
        input logic [CW-1:0] thr
    );
        if (mode) return (comp >= thr) ? {CW{1'b1}} : {CW{1'b0}};
        return ~comp;
    endfunction

    logic [C_CHANNELS*CW-1:0] op_data;

    always_comb begin
        op_data = s_axis_tdata;
        for (int c = 0; c < C_CHANNELS; c++) begin
            if (eff_en && eff_mask[c]) begin
                op_data[c*CW +: CW] = pixel_op(s_axis_tdata[c*CW +: CW], eff_mode, eff_thresh);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (s_fire) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= op_data;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Frame counter: clear from the bus takes priority over an increment
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            frames <= '0;
        end else if (wr_fire && wr_idx == REG_FRAMES) begin
            frames <= '0;
        end else if (m_fire && m_axis_tuser) begin
            frames <= frames + 32'd1;
        end
    end

    // Protection bits, byte-offset address bits and the unused part of the
    // merged write word carry no information for this register bank.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr, wr_merged};

endmodule
